// File: rtl/sliding_window_buffer_if.sv
// Streaming pixel-in / window-out bundle for sliding_window_buffer.
// The master drives the pixel stream; the slave (the buffer) returns the window.
interface sliding_window_buffer_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned K           = 3,
  parameter int unsigned COORD_WIDTH = 16
);
  logic                        en;
  logic                        sof;
  logic [DATA_WIDTH-1:0]       data;
  logic [K*K*DATA_WIDTH-1:0]   window;
  logic                        out_valid;
  logic [COORD_WIDTH-1:0]      x_out;
  logic [COORD_WIDTH-1:0]      y_out;

  modport master (
    output en, sof, data,
    input  window, out_valid, x_out, y_out
  );

  modport slave (
    input  en, sof, data,
    output window, out_valid, x_out, y_out
  );
endinterface

// File: rtl/sliding_window_buffer.sv
// KxK sliding-window generator: K-1 cascaded line RAMs feed K tap shift rows.
// A window is flagged valid only when all taps lie inside the current frame.
module sliding_window_buffer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned K            = 3,
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned COORD_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sliding_window_buffer_if.slave bus
);

  localparam int unsigned NumLines = K - 1;
  localparam int unsigned RamAw    = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned Half     = (K - 1) / 2;

  localparam logic [ADDR_WIDTH-1:0]  XLast = ADDR_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] YLast = COORD_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0]  XMin  = ADDR_WIDTH'(K - 1);
  localparam logic [COORD_WIDTH-1:0] YMin  = COORD_WIDTH'(K - 1);

  if ((K < 3) || (K > 7) || ((K % 2) == 0)) begin : gen_bad_k
    $error("sliding_window_buffer: K must be odd and within 3..7");
  end
  if (ADDR_WIDTH < RamAw) begin : gen_bad_aw
    $error("sliding_window_buffer: ADDR_WIDTH too small for FRAME_WIDTH");
  end

  // Raster position tracking
  logic [ADDR_WIDTH-1:0]  x_q, x_d;
  logic [COORD_WIDTH-1:0] y_q, y_d;
  logic [ADDR_WIDTH-1:0]  px;
  logic [COORD_WIDTH-1:0] py;

  // sof relabels the presented pixel as (0,0) whatever the counters say.
  assign px = bus.sof ? '0 : x_q;
  assign py = bus.sof ? '0 : y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (bus.en) begin
      if (px == XLast) begin
        x_d = '0;
        y_d = (py == YLast) ? '0 : py + COORD_WIDTH'(1);
      end else begin
        x_d = px + ADDR_WIDTH'(1);
        y_d = py;
      end
    end else if (bus.sof) begin
      x_d = '0;
      y_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Line buffers
  logic [RamAw-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] line_mem [NumLines][FRAME_WIDTH];
  logic [DATA_WIDTH-1:0] ram_rd   [NumLines];

  assign ram_addr = px[RamAw-1:0];

  always_comb begin
    for (int i = 0; i < NumLines; i++) begin
      ram_rd[i] = line_mem[i][ram_addr];
    end
  end

  // Read-before-write: each RAM takes the value the previous RAM held before this edge.
  always_ff @(posedge clk) begin
    if (bus.en) begin
      line_mem[0][ram_addr] <= bus.data;
      for (int i = 1; i < NumLines; i++) begin
        line_mem[i][ram_addr] <= ram_rd[i-1];
      end
    end
  end

  // Tap rows
  logic [DATA_WIDTH-1:0] row_in [K];
  logic [DATA_WIDTH-1:0] taps_q [K][K];
  logic [DATA_WIDTH-1:0] taps_d [K][K];

  always_comb begin
    row_in[K-1] = bus.data;
    for (int i = 0; i < NumLines; i++) begin
      row_in[K-2-i] = ram_rd[i];
    end
  end

  always_comb begin
    taps_d = taps_q;
    if (bus.en) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          taps_d[r][c] = taps_q[r][c+1];
        end
        taps_d[r][K-1] = row_in[r];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taps_q <= '{default: '0};
    end else begin
      taps_q <= taps_d;
    end
  end

  for (genvar r = 0; r < K; r++) begin : gen_row
    for (genvar c = 0; c < K; c++) begin : gen_col
      assign bus.window[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = taps_q[r][c];
    end
  end

  // Valid flag and centre coordinates
  logic                   win_hit;
  logic                   valid_q, valid_d;
  logic [COORD_WIDTH-1:0] x_out_q, x_out_d;
  logic [COORD_WIDTH-1:0] y_out_q, y_out_d;

  assign win_hit = bus.en && (px >= XMin) && (py >= YMin);

  // Coordinates keep the centre of the most recent valid window.
  always_comb begin
    valid_d = win_hit;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    if (win_hit) begin
      x_out_d = COORD_WIDTH'(px) - COORD_WIDTH'(Half);
      y_out_d = py - COORD_WIDTH'(Half);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      valid_q <= valid_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.x_out     = x_out_q;
  assign bus.y_out     = y_out_q;

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Directed-plus-random bench for sliding_window_buffer (K=3 8x6 and K=5 16x8 instances),
// checked against a frame-array reference model.
module tb_sliding_window_buffer;

  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sliding_window_buffer_if #(.DATA_WIDTH(8), .K(3), .COORD_WIDTH(16)) b3 ();
  sliding_window_buffer_if #(.DATA_WIDTH(8), .K(5), .COORD_WIDTH(16)) b5 ();

  sliding_window_buffer #(
    .DATA_WIDTH(8), .K(3), .FRAME_WIDTH(8), .FRAME_HEIGHT(6), .ADDR_WIDTH(4), .COORD_WIDTH(16)
  ) dut3 (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (b3.slave)
  );

  sliding_window_buffer #(
    .DATA_WIDTH(8), .K(5), .FRAME_WIDTH(16), .FRAME_HEIGHT(8), .ADDR_WIDTH(5), .COORD_WIDTH(16)
  ) dut5 (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (b5.slave)
  );

  int n_cmp;
  int n_bad;

  // Reference model state: frame geometry, next raster position, pixel store, last valid window.
  bit           sel5;
  int           mk, mw, mh, mx, my;
  logic [7:0]   pix [0:7][0:15];
  bit           hold_ok;
  bit           last_ev;
  logic [199:0] lw;
  int           lx, ly;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] dut_win();
    return sel5 ? 200'(b5.window) : 200'(b3.window);
  endfunction

  function automatic logic dut_ov();
    return sel5 ? b5.out_valid : b3.out_valid;
  endfunction

  function automatic logic [199:0] dut_x();
    return sel5 ? 200'(b5.x_out) : 200'(b3.x_out);
  endfunction

  function automatic logic [199:0] dut_y();
    return sel5 ? 200'(b5.y_out) : 200'(b3.y_out);
  endfunction

  task automatic model_restart(input bit k5);
    sel5    = k5;
    mk      = k5 ? 5 : 3;
    mw      = k5 ? 16 : 8;
    mh      = k5 ? 8 : 6;
    mx      = 0;
    my      = 0;
    hold_ok = 1'b0;
  endtask

  // One clock of stimulus, model update, then checks 1 time unit after the edge.
  task automatic step(input logic e, input logic s, input logic [7:0] d);
    int           px, py;
    logic         ev;
    logic [199:0] ew;
    if (sel5) begin
      b5.en = e; b5.sof = s; b5.data = d;
    end else begin
      b3.en = e; b3.sof = s; b3.data = d;
    end
    @(posedge clk);
    ev = 1'b0;
    if (e) begin
      px = s ? 0 : mx;
      py = s ? 0 : my;
      pix[py][px] = d;
      ev = (px >= mk - 1) && (py >= mk - 1);
      if (ev) begin
        ew = '0;
        for (int r = 0; r < mk; r++) begin
          for (int c = 0; c < mk; c++) begin
            ew[(r*mk+c)*8 +: 8] = pix[py-mk+1+r][px-mk+1+c];
          end
        end
        lw = ew;
        lx = px - (mk - 1) / 2;
        ly = py - (mk - 1) / 2;
      end
      hold_ok = ev;
      if (px == mw - 1) begin
        mx = 0;
        my = (py == mh - 1) ? 0 : py + 1;
      end else begin
        mx = px + 1;
        my = py;
      end
    end else if (s) begin
      mx = 0;
      my = 0;
    end
    last_ev = ev;
    #1;
    chk("out_valid", 200'(dut_ov()), 200'(ev));
    if (ev || (!e && hold_ok)) begin
      chk("window", dut_win(), lw);
      chk("x_out", dut_x(), 200'(lx));
      chk("y_out", dut_y(), 200'(ly));
    end
  endtask

  // One full frame of accepted pixels, first one tagged with sof; counts DUT pulses.
  task automatic run_frame(input bit ramp, input int gap_pct, output int np);
    int           acc, cx, cy;
    logic [7:0]   d;
    logic [199:0] w;
    acc = 0;
    np  = 0;
    while (acc < mw * mh) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        step(1'b0, 1'b0, 8'($urandom));
      end else begin
        cx = (acc == 0) ? 0 : mx;
        cy = (acc == 0) ? 0 : my;
        d  = ramp ? 8'(cy * 16 + cx) : 8'($urandom);
        step(1'b1, acc == 0, d);
        acc++;
        if (dut_ov()) np++;
        if (ramp && cx == mk - 1 && cy == mk - 1) begin
          w = dut_win();
          if (!sel5) begin
            chk("first_win3", w, 200'h222120121110020100);
            chk("first_x3", dut_x(), 200'd1);
            chk("first_y3", dut_y(), 200'd1);
          end else begin
            chk("first_tap00_5", 200'(w[7:0]), 200'h00);
            chk("first_x5", dut_x(), 200'd2);
            chk("first_y5", dut_y(), 200'd2);
          end
        end
      end
    end
  endtask

  initial begin
    int           np;
    logic [199:0] w;
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    b3.en = 1'b0; b3.sof = 1'b0; b3.data = '0;
    b5.en = 1'b0; b5.sof = 1'b0; b5.data = '0;
    model_restart(1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid3", 200'(b3.out_valid), 200'd0);
    chk("rst_win3", 200'(b3.window), 200'd0);
    chk("rst_x3", 200'(b3.x_out), 200'd0);
    chk("rst_y3", 200'(b3.y_out), 200'd0);
    chk("rst_valid5", 200'(b5.out_valid), 200'd0);
    chk("rst_win5", 200'(b5.window), 200'd0);
    reset_n = 1'b1;

    // Continuous ramp frame: first window, pulse count, last centre
    run_frame(1'b1, 0, np);
    chk("pulses_ramp", 200'(np), 200'((mw - mk + 1) * (mh - mk + 1)));
    w = dut_win();
    chk("last_x", dut_x(), 200'd6);
    chk("last_y", dut_y(), 200'd4);
    chk("last_centre_tap", 200'(w[4*8 +: 8]), 200'h46);

    // Same ramp frame with ~40% idle cycles
    run_frame(1'b1, 40, np);
    chk("pulses_gaps", 200'(np), 200'(24));

    // Random frame, then sof mid-frame at (5,3) starts a fresh random frame
    step(1'b1, 1'b1, 8'($urandom));
    while (!(mx == 5 && my == 3)) step(1'b1, 1'b0, 8'($urandom));
    run_frame(1'b0, 20, np);
    chk("pulses_sof", 200'(np), 200'(24));

    // sof without en forces (0,0) and accepts nothing
    step(1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, 8'($urandom));
    chk("sof_only_x", 200'(mx), 200'(0));

    // Asynchronous reset mid-line right after a valid pulse
    step(1'b1, 1'b1, 8'h00);
    while (!last_ev) step(1'b1, 1'b0, 8'(my * 16 + mx));
    b3.en = 1'b0;
    b3.sof = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 200'(b3.out_valid), 200'd0);
    chk("arst_win", 200'(b3.window), 200'd0);
    chk("arst_x", 200'(b3.x_out), 200'd0);
    chk("arst_y", 200'(b3.y_out), 200'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    model_restart(1'b0);
    run_frame(1'b1, 0, np);
    chk("pulses_after_rst", 200'(np), 200'(24));

    // K=5 instance: ramp frame then random data with gaps
    model_restart(1'b1);
    run_frame(1'b1, 0, np);
    chk("pulses_k5", 200'(np), 200'((mw - mk + 1) * (mh - mk + 1)));
    run_frame(1'b0, 30, np);
    chk("pulses_k5_rand", 200'(np), 200'(48));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
